// File: rtl/apv_gen_pkg.sv
// Shared types and frame geometry for the APV25 readout emulator.
//   apv_state_e : frame generator FSM states
//   *_LEN       : lengths of the fixed frame sections, in clocks
//   frame_len() : total frame length for a given sample count
package apv_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_ERR,
        ST_SAMP
    } apv_state_e;

    localparam int HDR_LEN  = 3;
    localparam int ADDR_LEN = 8;
    localparam int ERR_LEN  = 1;

    function automatic int frame_len(input int nsamp);
        return HDR_LEN + ADDR_LEN + ERR_LEN + nsamp;
    endfunction

endpackage

// File: rtl/apv_frame_gen_if.sv
// Sample-source bus for apv_frame_gen.
//   SMP_RD   : request from the generator; the current word is consumed on
//              every clock edge that ends a cycle with SMP_RD high
//   SMP_DATA : show-ahead sample word, channel k at [k*SW +: SW]
// master = generator side, slave = sample source side.
interface apv_frame_gen_if #(
    parameter int NCH = 8,
    parameter int SW  = 12
);
    logic                SMP_RD;
    logic [NCH*SW-1:0]   SMP_DATA;

    modport master (output SMP_RD, input SMP_DATA);
    modport slave  (input SMP_RD, output SMP_DATA);
endinterface

// File: rtl/apv_trig_decoder.sv
// APV trigger decoder and pending-frame counter.
//   CLK, RST : clock, synchronous active-high reset
//   TRIG     : APV trigger line; 1,0,0 on consecutive cycles is one trigger
//   NFRAME   : frames added per trigger (0 counts as 1), sampled on detection
//   DEC      : one frame taken by the generator this cycle
//   PEND     : saturating pending-frame count
//   OVF      : sticky, set when an add had to clamp PEND
module apv_trig_decoder #(
    parameter int PEND_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TRIG,
    input  logic [3:0]        NFRAME,
    input  logic              DEC,
    output logic [PEND_W-1:0] PEND,
    output logic              OVF
);
    // Wide enough for PEND_MAX + 15 without wrapping.
    localparam int            CW   = PEND_W + 5;
    localparam logic [CW-1:0] PMAX = CW'((1 << PEND_W) - 1);

    logic [1:0]    hist;   // [1] = TRIG two edges ago, [0] = one edge ago
    logic          det;
    logic          det_q;
    logic [3:0]    nf_q;
    logic [CW-1:0] inc;
    logic [CW-1:0] sum;

    // The pattern cannot overlap itself (it starts with 1 and continues
    // with 0s), so a plain shift history never shares bits between hits.
    assign det = hist[1] & ~hist[0] & ~TRIG;

    always_comb begin
        inc = '0;
        if (det_q)
            inc = (nf_q == 4'd0) ? CW'(1) : CW'(nf_q);
        sum = CW'(PEND) + inc;
        if (DEC && sum != '0)
            sum = sum - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hist  <= '0;
            det_q <= 1'b0;
            nf_q  <= '0;
            PEND  <= '0;
            OVF   <= 1'b0;
        end else begin
            hist  <= {hist[0], TRIG};
            det_q <= det;
            nf_q  <= NFRAME;
            if (sum > PMAX) begin
                PEND <= PMAX[PEND_W-1:0];
                OVF  <= 1'b1;
            end else begin
                PEND <= sum[PEND_W-1:0];
            end
        end
    end

endmodule

// File: rtl/apv_frame_gen.sv
// APV25 readout emulator: sync ticks while idle, and NFRAME frames per
// decoded trigger (header, 8-bit address MSB first, error bit, NSAMP samples).
//   CLK, RST      : clock, synchronous active-high reset
//   ENABLE        : generator enable (an in-progress frame always completes)
//   TRIG          : APV trigger line
//   NFRAME        : frames per trigger
//   ADDR, ERR_N   : frame address and error bit (1 = no error)
//   smp           : sample source bus (SMP_RD request, show-ahead SMP_DATA)
//   DATA_OUT      : per-channel output words, channel k at [k*SW +: SW]
//   SYNC_TICK     : idle tick cycle
//   FRAME_ACTIVE  : frame cycle
//   PEND, OVF     : pending frame count, sticky overflow
//   FRAME_CNT     : frames emitted, wraps
// All outputs are registered. state/cnt describe the cycle currently on the
// outputs; a boundary is the edge that follows an idle slot's last cycle or
// a frame's last sample (or reset), where the next frame may start.
module apv_frame_gen
    import apv_gen_pkg::*;
#(
    parameter int            NCH         = 8,
    parameter int            SW          = 12,
    parameter logic [SW-1:0] ONE_LVL     = 12'hB00,
    parameter logic [SW-1:0] ZERO_LVL    = 12'h200,
    parameter int            NSAMP       = 128,
    parameter int            SYNC_PERIOD = 35,
    parameter int            PEND_W      = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENABLE,
    input  logic               TRIG,
    input  logic [3:0]         NFRAME,
    input  logic [7:0]         ADDR,
    input  logic               ERR_N,
    apv_frame_gen_if.master    smp,
    output logic [NCH*SW-1:0]  DATA_OUT,
    output logic               SYNC_TICK,
    output logic               FRAME_ACTIVE,
    output logic [PEND_W-1:0]  PEND,
    output logic               OVF,
    output logic [15:0]        FRAME_CNT
);
    localparam int CNT_MAX0 = (NSAMP > SYNC_PERIOD) ? NSAMP : SYNC_PERIOD;
    localparam int CNT_MAX  = (CNT_MAX0 > ADDR_LEN) ? CNT_MAX0 : ADDR_LEN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] HDR_LAST    = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST   = CNT_W'(ADDR_LEN - 1);
    localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'(NSAMP - 1);
    localparam logic [CNT_W-1:0] IDLE_RELOAD = CNT_W'(SYNC_PERIOD - 1);

    apv_state_e       state, nstate;
    logic [CNT_W-1:0] cnt, ncnt;     // IDLE: cycles left in slot; else index
    logic             boundary;
    logic             dec;
    logic             tick;
    logic [SW-1:0]    lvl;
    logic [NCH*SW-1:0] data_nxt;
    logic             rd_nxt;
    logic             fcnt_inc;

    apv_trig_decoder #(.PEND_W(PEND_W)) u_trig (
        .CLK    (CLK),
        .RST    (RST),
        .TRIG   (TRIG),
        .NFRAME (NFRAME),
        .DEC    (dec),
        .PEND   (PEND),
        .OVF    (OVF)
    );

    always_comb begin
        nstate   = state;
        ncnt     = cnt;
        tick     = 1'b0;
        dec      = 1'b0;
        boundary = (state == ST_IDLE && cnt == '0) ||
                   (state == ST_SAMP && cnt == SAMP_LAST);

        if (boundary) begin
            if (ENABLE && PEND != '0) begin
                nstate = ST_HDR;
                ncnt   = '0;
                dec    = 1'b1;
            end else begin
                // Slot timing runs even when disabled; only the tick is gated.
                nstate = ST_IDLE;
                ncnt   = IDLE_RELOAD;
                tick   = ENABLE;
            end
        end else begin
            case (state)
                ST_IDLE: ncnt = cnt - C_ONE;
                ST_HDR: begin
                    if (cnt == HDR_LAST) begin
                        nstate = ST_ADDR;
                        ncnt   = '0;
                    end else begin
                        ncnt = cnt + C_ONE;
                    end
                end
                ST_ADDR: begin
                    if (cnt == ADDR_LAST) begin
                        nstate = ST_ERR;
                        ncnt   = '0;
                    end else begin
                        ncnt = cnt + C_ONE;
                    end
                end
                ST_ERR: begin
                    nstate = ST_SAMP;
                    ncnt   = '0;
                end
                default: ncnt = cnt + C_ONE;
            endcase
        end

        // Output values for the cycle being entered.
        case (nstate)
            ST_IDLE: lvl = tick ? ONE_LVL : ZERO_LVL;
            ST_HDR:  lvl = ONE_LVL;
            ST_ADDR: lvl = ADDR[3'(ADDR_LEN - 1) - ncnt[2:0]] ? ONE_LVL : ZERO_LVL;
            ST_ERR:  lvl = ERR_N ? ONE_LVL : ZERO_LVL;
            default: lvl = ZERO_LVL;
        endcase
        data_nxt = (nstate == ST_SAMP) ? smp.SMP_DATA : {NCH{lvl}};
        // Show-ahead source: the word read at the edge ending an SMP_RD cycle
        // is the one shown in the following SAMP cycle, so reads start at ERR
        // and stop one cycle before the last sample.
        rd_nxt   = (nstate == ST_ERR) || (nstate == ST_SAMP && ncnt != SAMP_LAST);
        fcnt_inc = (nstate == ST_SAMP && ncnt == SAMP_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            DATA_OUT     <= {NCH{ZERO_LVL}};
            SYNC_TICK    <= 1'b0;
            FRAME_ACTIVE <= 1'b0;
            smp.SMP_RD   <= 1'b0;
            FRAME_CNT    <= '0;
        end else begin
            state        <= nstate;
            cnt          <= ncnt;
            DATA_OUT     <= data_nxt;
            SYNC_TICK    <= tick;
            FRAME_ACTIVE <= (nstate != ST_IDLE);
            smp.SMP_RD   <= rd_nxt;
            if (fcnt_inc)
                FRAME_CNT <= FRAME_CNT + 16'd1;
        end
    end

endmodule

// File: tb/tb_apv_frame_gen.sv
module tb_apv_frame_gen;
    import apv_gen_pkg::*;

    localparam int            NCH   = 8;
    localparam int            SW    = 12;
    localparam int            NSAMP = 128;
    localparam int            SP    = 35;
    localparam int            PW    = 4;
    localparam int            PMAX  = (1 << PW) - 1;
    localparam int            FLEN  = frame_len(NSAMP);
    localparam logic [SW-1:0] ONE   = 12'hB00;
    localparam logic [SW-1:0] ZERO  = 12'h200;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             ENABLE = 1'b0;
    logic             TRIG = 1'b0;
    logic [3:0]       NFRAME = 4'd1;
    logic [7:0]       ADDR = 8'h00;
    logic             ERR_N = 1'b1;
    logic [NCH*SW-1:0] DATA_OUT;
    logic             SYNC_TICK, FRAME_ACTIVE, OVF;
    logic [PW-1:0]    PEND;
    logic [15:0]      FRAME_CNT;

    apv_frame_gen_if #(.NCH(NCH), .SW(SW)) smp ();

    apv_frame_gen #(
        .NCH(NCH), .SW(SW), .ONE_LVL(ONE), .ZERO_LVL(ZERO),
        .NSAMP(NSAMP), .SYNC_PERIOD(SP), .PEND_W(PW)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .TRIG(TRIG), .NFRAME(NFRAME),
        .ADDR(ADDR), .ERR_N(ERR_N), .smp(smp), .DATA_OUT(DATA_OUT),
        .SYNC_TICK(SYNC_TICK), .FRAME_ACTIVE(FRAME_ACTIVE), .PEND(PEND),
        .OVF(OVF), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NCH*SW-1:0] data;
        logic              tick, act, rd, ovf;
        logic [PW-1:0]     pend;
        logic [15:0]       fcnt;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0, n_bad = 0;
    int   tick_cnt = 0, run = 0, max_run = 0;
    bit   ramp_mode = 1'b1;
    int   src_idx = 0;

    // Reference model state: frame position (-1 = idle), idle cycles left
    // before the next boundary, pending frames, trigger history.
    int   m_pos = -1, m_idle = 0, m_pend = 0, m_nf = 0, m_fcnt = 0;
    bit   m_ovf = 0, m_h0 = 0, m_h1 = 0, m_det = 0;

    function automatic logic [NCH*SW-1:0] bcast(input logic [SW-1:0] v);
        logic [NCH*SW-1:0] w;
        for (int c = 0; c < NCH; c++) w[c*SW +: SW] = v;
        return w;
    endfunction

    function automatic logic [NCH*SW-1:0] make_word(input int idx);
        logic [NCH*SW-1:0] w;
        for (int c = 0; c < NCH; c++)
            w[c*SW +: SW] = ramp_mode ? SW'(idx * 4 + c) : SW'($urandom);
        return w;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of the spec behaviour: inputs seen now are taken by the DUT at
    // the next edge; the result is what the outputs must show after it.
    task automatic model_step();
        exp_t e;
        int   inc;
        bit   bnd, start, tick;
        tick = 0;
        if (RST) begin
            m_pos = -1; m_idle = 0; m_pend = 0; m_ovf = 0;
            m_h0 = 0; m_h1 = 0; m_det = 0; m_nf = 0; m_fcnt = 0;
        end else begin
            inc   = m_det ? ((m_nf == 0) ? 1 : m_nf) : 0;
            bnd   = (m_pos < 0 && m_idle == 0) || (m_pos == FLEN - 1);
            start = bnd && ENABLE && m_pend > 0;
            m_pend = m_pend + inc - (start ? 1 : 0);
            if (m_pend > PMAX) begin m_pend = PMAX; m_ovf = 1; end
            m_det = m_h1 && !m_h0 && !TRIG;
            m_nf  = int'(NFRAME);
            m_h1  = m_h0;
            m_h0  = TRIG;
            if (bnd) begin
                if (start) m_pos = 0;
                else begin m_pos = -1; m_idle = SP - 1; tick = ENABLE; end
            end else if (m_pos >= 0) m_pos++;
            else m_idle--;
            if (m_pos == FLEN - 1) m_fcnt = (m_fcnt + 1) % 65536;
        end
        if (m_pos < 0)                       e.data = bcast(tick ? ONE : ZERO);
        else if (m_pos < HDR_LEN)            e.data = bcast(ONE);
        else if (m_pos < HDR_LEN + ADDR_LEN) e.data = bcast(ADDR[HDR_LEN + ADDR_LEN - 1 - m_pos] ? ONE : ZERO);
        else if (m_pos == HDR_LEN + ADDR_LEN) e.data = bcast(ERR_N ? ONE : ZERO);
        else                                 e.data = smp.SMP_DATA;
        e.tick = tick;
        e.act  = (m_pos >= 0);
        e.rd   = (m_pos >= HDR_LEN + ADDR_LEN) && (m_pos < FLEN - 1);
        e.ovf  = m_ovf;
        e.pend = PW'(m_pend);
        e.fcnt = 16'(m_fcnt);
        expq.push_back(e);
    endtask

    // Monitor: compare what the DUT shows against the queued expectation,
    // then queue the expectation for the next cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("data_out",     128'(DATA_OUT),     128'(e.data));
                chk("sync_tick",    128'(SYNC_TICK),    128'(e.tick));
                chk("frame_active", 128'(FRAME_ACTIVE), 128'(e.act));
                chk("smp_rd",       128'(smp.SMP_RD),   128'(e.rd));
                chk("pend",         128'(PEND),         128'(e.pend));
                chk("ovf",          128'(OVF),          128'(e.ovf));
                chk("frame_cnt",    128'(FRAME_CNT),    128'(e.fcnt));
            end
            if (SYNC_TICK === 1'b1) tick_cnt++;
            run = (FRAME_ACTIVE === 1'b1) ? run + 1 : 0;
            if (run > max_run) max_run = run;
            model_step();
        end
    end

    // Show-ahead sample source: a word is consumed by each edge ending a
    // cycle with SMP_RD high, and the next word is presented after it.
    initial begin
        bit rd_seen;
        smp.SMP_DATA = make_word(0);
        forever begin
            @(negedge CLK);
            rd_seen = (smp.SMP_RD === 1'b1);
            @(posedge CLK);
            #1;
            if (rd_seen) begin
                src_idx++;
                smp.SMP_DATA = make_word(src_idx);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic trig_pulse();
        TRIG = 1'b1; step();
        TRIG = 1'b0; step(2);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!(m_pend == 0 && m_pos < 0 && !m_det) && n < budget) begin step(); n++; end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL %s: no drain within %0d cycles", name, budget);
        end
        step(2);
    endtask

    task automatic wait_pos(input int target, input int budget, input string name);
        int n = 0;
        while (m_pos < target && n < budget) begin step(); n++; end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL %s: frame position %0d not reached in %0d cycles", name, target, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ENABLE = 1'b1;
        step(3);
        RST = 1'b0;
        tick_cnt = 0;

        // Idle ticks: first at the boundary after reset, then every SP cycles.
        step(400);
        chk("idle_ticks", 128'(tick_cnt), 128'd12);

        // Single trigger, ramp samples.
        ADDR = 8'h55; ERR_N = 1'b1; NFRAME = 4'd1;
        trig_pulse();
        wait_idle(500, "single_frame");
        chk("single_fcnt", 128'(FRAME_CNT), 128'd1);
        chk("single_pend", 128'(PEND), 128'd0);

        // Three frames from one trigger, back-to-back.
        max_run = 0; NFRAME = 4'd3; ADDR = 8'hA3; ERR_N = 1'b0;
        trig_pulse();
        wait_idle(800, "three_frames");
        chk("three_run", 128'(max_run), 128'(3 * FLEN));
        chk("three_fcnt", 128'(FRAME_CNT), 128'd4);

        // Second trigger while the first frame is in SAMP.
        max_run = 0; NFRAME = 4'd1; ERR_N = 1'b1;
        trig_pulse();
        wait_pos(20, 100, "reach_samp");
        trig_pulse();
        step();
        chk("mid_frame_pend", 128'(PEND), 128'd1);
        wait_idle(600, "two_frames");
        chk("two_run", 128'(max_run), 128'(2 * FLEN));
        chk("two_fcnt", 128'(FRAME_CNT), 128'd6);

        // Pending-counter overflow.
        NFRAME = 4'd15;
        trig_pulse();
        step(3);
        trig_pulse();
        step();
        chk("ovf_pend", 128'(PEND), 128'(PMAX));
        chk("ovf_set", 128'(OVF), 128'd1);
        wait_idle(6000, "ovf_drain");
        chk("ovf_drained_pend", 128'(PEND), 128'd0);
        chk("ovf_sticky", 128'(OVF), 128'd1);

        // Reset in the middle of the sample section.
        NFRAME = 4'd1;
        trig_pulse();
        wait_pos(60, 100, "reach_mid_samp");
        RST = 1'b1;
        step();
        chk("rst_data", 128'(DATA_OUT), 128'(bcast(ZERO)));
        chk("rst_active", 128'(FRAME_ACTIVE), 128'd0);
        chk("rst_smp_rd", 128'(smp.SMP_RD), 128'd0);
        chk("rst_ovf", 128'(OVF), 128'd0);
        chk("rst_fcnt", 128'(FRAME_CNT), 128'd0);
        RST = 1'b0;
        step();
        chk("first_tick_after_rst", 128'(SYNC_TICK), 128'd1);

        // Randomised traffic: triggers, NFRAME, address/error bits, enable.
        ramp_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            TRIG   = ($urandom_range(63) == 0);
            NFRAME = 4'($urandom_range(3));
            ADDR   = 8'($urandom);
            ERR_N  = 1'($urandom);
            if ($urandom_range(199) == 0) ENABLE = ~ENABLE;
            step();
        end
        TRIG = 1'b0; ENABLE = 1'b1;
        wait_idle(8000, "random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apv_frame_gen.md
# apv_frame_gen

Parametrised, synthesisable APV25 readout emulator for the MPD front-end test path. It generates per-channel parallel ADC sample words that reproduce APV output: periodic sync ticks while idle, and on each decoded `100` trigger, a programmable number of frames. Each frame carries a header, an 8-bit address, an error bit and NSAMP samples pulled from an external sample source. It sits upstream of the APV frame decoder/processor, in place of the ADC deserialiser, for bench and in-FPGA self-test.

## Interface
- `NCH`, 8, number of channels.
- `SW`, 12, sample width in bits.
- `ONE_LVL`, 12'hB00, digital-one level (SW bits).
- `ZERO_LVL`, 12'h200, digital-zero / baseline level.
- `NSAMP`, 128, samples per frame.
- `SYNC_PERIOD`, 35, idle tick period in clocks.
- `PEND_W`, 4, pending-trigger counter width.
- `CLK` in 1: system clock.
- `RST` in 1: reset, synchronous, active-high.
- `ENABLE` in 1: generator enable.
- `TRIG` in 1: APV trigger line; `100` over 3 consecutive cycles is one trigger.
- `NFRAME` in 4: frames per trigger, 1..15; 0 is treated as 1.
- `ADDR` in 8: frame address, transmitted MSB first.
- `ERR_N` in 1: error bit value; 1 means no error.
- `SMP_RD` out 1: sample request.
- `SMP_DATA` in NCH*SW: samples; channel k is at [k*SW +: SW].
- `DATA_OUT` out NCH*SW: emitted words.
- `SYNC_TICK` out 1: high in idle tick cycles.
- `FRAME_ACTIVE` out 1: high during frame cycles.
- `PEND` out PEND_W: pending trigger count.
- `OVF` out 1: sticky pending-counter overflow.
- `FRAME_CNT` out 16: frames emitted, wraps.

## Operation
- Trigger decoder detects TRIG = 1, 0, 0 on three consecutive cycles.
  - Each detection increments PEND by NFRAME, sampled at the detection edge.
  - Overlapping patterns share no bits: `10010` is one trigger.
- PEND saturates at 2^PEND_W-1. An add that would exceed this clamps to the maximum and sets OVF. OVF clears only on RST.
- FSM states: IDLE, HDR(3), ADDR(8), ERR(1), SAMP(NSAMP). A frame occupies 12+NSAMP cycles (140 by default).
- Boundary cycle:
  - IDLE slot counter = 0; or
  - the cycle after the last SAMP cycle.
- Decision at a boundary:
  - ENABLE=1 and PEND>0: enter HDR and decrement PEND.
  - Otherwise: stay in IDLE. If ENABLE=1, emit ONE_LVL with SYNC_TICK=1 for 1 cycle, then ZERO_LVL for SYNC_PERIOD-1 cycles.
- Output levels (all channels identical until SAMP):
  - HDR: ONE.
  - ADDR: bit ? ONE : ZERO.
  - ERR: ERR_N ? ONE : ZERO.
- SAMP: DATA_OUT = SMP_DATA registered.
- Frames for consecutive triggers, and the NFRAME frames within one trigger, run back-to-back with no gap.
- FRAME_CNT increments at each frame's last SAMP cycle.
- ENABLE=0 in IDLE: DATA_OUT=ZERO, no ticks, triggers still counted. A frame already in progress always completes.
- Simultaneous increment and decrement in the same cycle: PEND += NFRAME-1, saturating.

## Timing
- All outputs are registered.
- Reset values:
  - DATA_OUT: all ZERO_LVL.
  - SYNC_TICK, FRAME_ACTIVE, SMP_RD, OVF: 0.
  - PEND, FRAME_CNT: 0.
  - FSM: IDLE, slot counter 0.
- The first cycle after RST deassert is a boundary.
- Trigger latency: detection at edge t (second 0 sampled) updates PEND at t+1. The frame starts at the next boundary, i.e. within SYNC_PERIOD cycles.
- SMP_RD is high during ERR and the first NSAMP-1 SAMP cycles.
- SMP_DATA uses show-ahead semantics: it is sampled on the edge ending each SMP_RD cycle and appears on DATA_OUT the next cycle.
- RST mid-frame aborts the frame immediately and returns all outputs to their reset values. SMP_RD drops in the same edge.

## Structure
- Package `apv_gen_pkg`:
  - state enum;
  - HDR_LEN=3, ADDR_LEN=8, ERR_LEN=1;
  - function returning frame length from NSAMP.
- Sub-module `apv_trig_decoder`: the `100` detector plus the saturating PEND/OVF counter, with inc-by-NFRAME and dec-by-1 ports.
- Top level: FSM, slot/sample counters and output mux.

## Test plan
- Idle, ENABLE=1, 400 cycles → SYNC_TICK on cycles 0, 35, 70, …; DATA_OUT is 12'hB00 on tick cycles, 12'h200 otherwise.
- One `100` trigger, NFRAME=1, ADDR=8'h55, ERR_N=1, ramp SMP_DATA:
  - frame is HDR 1,1,1; address 0,1,0,1,0,1,0,1; error 1; then 128 samples matching the source order;
  - FRAME_CNT=1; PEND back to 0.
- NFRAME=3, one trigger → 420 contiguous FRAME_ACTIVE cycles, no tick in between, FRAME_CNT=3.
- Second trigger during SAMP → PEND=1 after detection; the second frame starts the cycle after the first frame's last sample.
- PEND_W=4, NFRAME=15, two triggers → PEND=15, OVF=1; OVF persists after PEND drains.
- RST asserted mid-SAMP → next cycle all outputs at reset values; the first tick follows reset release.
